// File: rtl/stack_pkg.sv
// Shared command/mode encodings and modular pointer arithmetic for stack_param.
package stack_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_GET  = 2'b11;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Both operands must already be below depth, so one conditional subtract wraps.
  function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned off,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + off;
    return (sum >= depth) ? sum - depth : sum;
  endfunction

endpackage

// File: rtl/stack_param_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port, no reset.
module stack_param_regfile #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_param.sv
// Parametrised command-driven stack/queue on a circular buffer with runtime LIFO/FIFO mode.
module stack_param
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned IDX_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       COMMAND,
  input  logic [IDX_W-1:0] INDEX,
  input  logic             MODE,
  input  logic [WIDTH-1:0] I_DATA,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_VALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT,
  output logic             ERR
);

  logic [IDX_W-1:0] wp_q, wp_d;
  logic [IDX_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d;
  logic             err_q, err_d;

  logic             full, empty, index_ok, eff_mode, we;
  logic [IDX_W-1:0] wp_inc, wp_dec, rp_inc, rd_addr;
  logic [WIDTH-1:0] rd_data;
  int unsigned      rd_off;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Mode is only sampled while empty, so a PUSH into an empty buffer already uses the new mode.
  assign eff_mode = empty ? MODE : mode_q;
  assign index_ok = (32'(INDEX) < 32'(count_q));

  assign wp_inc = IDX_W'(wrap_add(32'(wp_q), 1, DEPTH));
  assign wp_dec = IDX_W'(wrap_add(32'(wp_q), DEPTH - 1, DEPTH));
  assign rp_inc = IDX_W'(wrap_add(32'(rp_q), 1, DEPTH));

  // POP is a GET at offset 0; an invalid index reads offset 0 so the address stays in range.
  always_comb begin
    rd_off = 0;
    if (COMMAND == CMD_GET && index_ok) begin
      rd_off = 32'(INDEX);
    end
    if (eff_mode == MODE_FIFO) begin
      rd_addr = IDX_W'(wrap_add(32'(rp_q), rd_off, DEPTH));
    end else begin
      rd_addr = IDX_W'(wrap_add(32'(wp_q), DEPTH - 1 - rd_off, DEPTH));
    end
  end

  stack_param_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk   (CLK),
    .we    (we),
    .waddr (wp_q),
    .wdata (I_DATA),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    mode_d    = eff_mode;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    err_d     = 1'b0;
    we        = 1'b0;

    unique case (COMMAND)
      CMD_NOP: ;
      CMD_PUSH: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          we      = 1'b1;
          wp_d    = wp_inc;
          count_d = count_q + CNT_W'(1);
        end
      end
      CMD_POP: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          o_data_d  = rd_data;
          o_valid_d = 1'b1;
          count_d   = count_q - CNT_W'(1);
          if (eff_mode == MODE_FIFO) begin
            rp_d = rp_inc;
          end else begin
            wp_d = wp_dec;
          end
        end
      end
      CMD_GET: begin
        if (!index_ok) begin
          err_d = 1'b1;
        end else begin
          o_data_d  = rd_data;
          o_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      mode_q    <= MODE_LIFO;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      err_q     <= err_d;
    end
  end

  assign O_DATA  = o_data_q;
  assign O_VALID = o_valid_q;
  assign ERR     = err_q;
  assign COUNT   = count_q;
  assign FULL    = full;
  assign EMPTY   = empty;

endmodule

// File: tb/tb_stack_param.sv
// Directed table-driven bench for stack_param at WIDTH=4, DEPTH=5.
module tb_stack_param;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] GET  = 2'b11;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       COMMAND;
  logic [IDX_W-1:0] INDEX;
  logic             MODE;
  logic [WIDTH-1:0] I_DATA;
  logic [WIDTH-1:0] O_DATA;
  logic             O_VALID, FULL, EMPTY, ERR;
  logic [CNT_W-1:0] COUNT;

  stack_param #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .COMMAND (COMMAND),
    .INDEX   (INDEX),
    .MODE    (MODE),
    .I_DATA  (I_DATA),
    .O_DATA  (O_DATA),
    .O_VALID (O_VALID),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]       cmd;
    logic [IDX_W-1:0] idx;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             err;
    logic [CNT_W-1:0] count;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic [1:0] cmd, input int idx, input logic mode,
                              input int din, input int data, input logic valid,
                              input logic err, input int count);
    vec_t v;
    v.cmd   = cmd;
    v.idx   = IDX_W'(idx);
    v.mode  = mode;
    v.din   = WIDTH'(din);
    v.data  = WIDTH'(data);
    v.valid = valid;
    v.err   = err;
    v.count = CNT_W'(count);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int data, input logic valid, input logic err,
                       input int count);
    logic efull, eempty;
    efull  = (count == DEPTH);
    eempty = (count == 0);
    n_vec++;
    if (O_DATA !== WIDTH'(data) || O_VALID !== valid || ERR !== err ||
        COUNT !== CNT_W'(count) || FULL !== efull || EMPTY !== eempty) begin
      n_bad++;
      $display("FAIL %s: got data=%0d valid=%0b err=%0b count=%0d full=%0b empty=%0b, want data=%0d valid=%0b err=%0b count=%0d full=%0b empty=%0b",
               name, O_DATA, O_VALID, ERR, COUNT, FULL, EMPTY,
               data, valid, err, count, efull, eempty);
    end
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [IDX_W-1:0] idx, input logic mode,
                       input logic [WIDTH-1:0] din);
    @(negedge CLK);
    COMMAND = cmd;
    INDEX   = idx;
    MODE    = mode;
    I_DATA  = din;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: fill, overflow, GET top
    for (int i = 1; i <= 5; i++) add(PUSH, 0, 0, i, 0, 0, 0, i);
    add(PUSH, 0, 0, 6, 0, 0, 1, 5);
    add(GET, 0, 0, 0, 5, 1, 0, 5);
    // Scenario 2: LIFO GET by depth, out-of-range index
    for (int i = 0; i <= 4; i++) add(GET, i, 0, 0, 5 - i, 1, 0, 5);
    add(GET, 5, 0, 0, 1, 0, 1, 5);
    // Scenario 3: alternating POP / GET 0
    for (int i = 5; i >= 2; i--) begin
      add(POP, 0, 0, 0, i, 1, 0, i - 1);
      add(GET, 0, 0, 0, i - 1, 1, 0, i - 1);
    end
    add(POP, 0, 0, 0, 1, 1, 0, 0);
    add(GET, 0, 0, 0, 1, 0, 1, 0);
    // Scenario 4: underflow then NOP clears ERR
    add(POP, 0, 0, 0, 1, 0, 1, 0);
    add(NOP, 0, 0, 0, 1, 0, 0, 0);
    // Scenario 5: FIFO with wrap
    for (int i = 1; i <= 5; i++) add(PUSH, 0, 1, i, 1, 0, 0, i);
    add(POP, 0, 1, 0, 1, 1, 0, 4);
    add(POP, 0, 1, 0, 2, 1, 0, 3);
    add(PUSH, 0, 1, 6, 2, 0, 0, 4);
    add(PUSH, 0, 1, 7, 2, 0, 0, 5);
    for (int i = 0; i <= 4; i++) add(GET, i, 1, 0, 3 + i, 1, 0, 5);
    for (int i = 0; i <= 4; i++) add(POP, 0, 1, 0, 3 + i, 1, 0, 4 - i);
    // Scenario 6: MODE flips to LIFO while non-empty, FIFO order persists
    add(PUSH, 0, 1, 8, 7, 0, 0, 1);
    add(PUSH, 0, 1, 9, 7, 0, 0, 2);
    add(PUSH, 0, 1, 10, 7, 0, 0, 3);
    add(GET, 0, 0, 0, 8, 1, 0, 3);
    add(POP, 0, 0, 0, 8, 1, 0, 2);
    add(POP, 0, 0, 0, 9, 1, 0, 1);
    add(POP, 0, 0, 0, 10, 1, 0, 0);
    // Drained with MODE=0: now LIFO
    add(PUSH, 0, 0, 11, 10, 0, 0, 1);
    add(PUSH, 0, 0, 12, 10, 0, 0, 2);
    add(GET, 0, 0, 0, 12, 1, 0, 2);

    RESET   = 1'b0;
    COMMAND = NOP;
    INDEX   = '0;
    MODE    = 1'b0;
    I_DATA  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cmd, vecs[i].idx, vecs[i].mode, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].data, vecs[i].valid, vecs[i].err, vecs[i].count);
    end

    // Asynchronous reset while a GET result is being presented
    drive(GET, 3'd1, 1'b0, 4'd0);
    check("get_before_reset", 11, 1, 0, 2);
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0);
    @(negedge CLK);
    RESET   = 1'b1;
    COMMAND = PUSH;
    I_DATA  = 4'd3;
    MODE    = 1'b0;
    @(posedge CLK);
    #1;
    check("push_after_reset", 0, 0, 0, 1);
    drive(GET, 3'd0, 1'b0, 4'd0);
    check("get_after_reset", 3, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_param.md
Name: stack_param

Overview:
- Parametrised successor to the fixed 4-bit, 5-entry command-driven stack.
- Generalises data width and depth, and replaces the bidirectional data bus with separate input and output buses.
- Adds full/empty/count status, an error pulse, and a runtime LIFO/FIFO mode.
- Sits as a local operand/scratch store driven by a controller issuing NOP/PUSH/POP/GET each cycle.

Parameters:
WIDTH, 4, data word width in bits
DEPTH, 5, number of entries (>=2, need not be a power of two)
IDX_W, $clog2(DEPTH), width of INDEX and of pointers
CNT_W, $clog2(DEPTH+1), width of COUNT

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
COMMAND  input  2  00 NOP, 01 PUSH, 10 POP, 11 GET
INDEX  input  IDX_W  GET offset from the read end
MODE  input  1  0 LIFO, 1 FIFO; latched only when COUNT==0
I_DATA  input  WIDTH  PUSH data
O_DATA  output  WIDTH  registered read data
O_VALID  output  1  O_DATA holds the result of the previous-cycle POP/GET
FULL  output  1  COUNT==DEPTH
EMPTY  output  1  COUNT==0
COUNT  output  CNT_W  current occupancy
ERR  output  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (RESET low, asynchronous): COUNT=0, head=tail=0, mode_q=0 (LIFO), O_DATA=0, O_VALID=0, ERR=0, EMPTY=1, FULL=0.
- Memory contents are not cleared on reset.
- Storage is a circular buffer with a write pointer wp, a read-base pointer rp and COUNT. Pointers increment/decrement modulo DEPTH, with explicit wrap at DEPTH-1 (no power-of-two assumption).
- PUSH, not full: mem[wp]<=I_DATA, wp<=wp+1, COUNT+1. O_VALID<=0.
- PUSH, full: state unchanged; ERR=1 next cycle. No overwrite.
- POP, LIFO: O_DATA<=mem[wp-1], wp<=wp-1, COUNT-1.
- POP, FIFO: O_DATA<=mem[rp], rp<=rp+1, COUNT-1.
- POP, either mode: O_VALID<=1.
- POP, empty: state unchanged, O_VALID<=0, ERR=1, O_DATA holds its previous value.
- GET, INDEX<COUNT, LIFO: O_DATA<=mem[wp-1-INDEX].
- GET, INDEX<COUNT, FIFO: O_DATA<=mem[rp+INDEX].
- GET, valid index, either mode: all arithmetic is mod DEPTH; O_VALID<=1; no state change.
- GET, INDEX>=COUNT (including empty): O_VALID<=0, ERR=1, O_DATA holds.
- NOP: O_VALID<=0, ERR<=0; all other outputs hold.
- Latency: every command takes 1 cycle. O_DATA/O_VALID/ERR appear on the edge following the command edge. FULL/EMPTY/COUNT reflect state after that edge.
- ERR is a 1-cycle pulse, registered, and deasserts on the next non-erroring command.
- MODE: mode_q<=MODE on any edge where COUNT==0 before the command. A MODE change while non-empty is ignored until the buffer drains. A PUSH on an empty buffer uses the newly sampled mode for all later reads.
- When COUNT returns to 0, wp and rp need not be realigned. Correctness depends only on COUNT and the pointers.
- Reset mid-operation: an asynchronous assert cancels any in-flight result. O_VALID drops immediately. The first command after deassert is honoured on the next rising edge.
- I_DATA containing X/Z while not PUSHing must not propagate to any output.

Decomposition:
- Package stack_pkg holds:
  - command constants CMD_NOP/CMD_PUSH/CMD_POP/CMD_GET;
  - mode constants MODE_LIFO/MODE_FIFO;
  - a function wrap_add(ptr, off, DEPTH) for modular pointer arithmetic.
- One natural sub-module, stack_param_regfile: a DEPTH x WIDTH register array with 1 synchronous write port and 1 combinational read port, no reset.

Test Plan (WIDTH=4, DEPTH=5):
1. Reset, PUSH 1..5 -> FULL=1, COUNT=5. A 6th PUSH of 6 -> ERR pulse, COUNT stays 5, GET 0 returns 5.
2. LIFO: after scenario 1, GET INDEX 0..4 -> O_DATA 5,4,3,2,1 with O_VALID=1. GET INDEX 5 (IDX_W=3) -> ERR, O_VALID=0.
3. LIFO, 5 alternating POP/GET 0 -> POPs return 5,4,3,2,1. GETs return 4,3,2,1, and the final GET errors with EMPTY=1.
4. POP on empty -> ERR=1, O_VALID=0, COUNT=0. Then NOP -> ERR=0.
5. FIFO, MODE=1 while empty: PUSH 1..5, POP x2 (returns 1,2), PUSH 6,7 (wrap) -> GET 0..4 returns 3,4,5,6,7. POPs drain 3,4,5,6,7.
6. Set MODE 1->0 with COUNT=3 -> FIFO order persists until empty. Then assert RESET low mid-GET -> O_VALID=0 and COUNT=0 immediately, with no clock edge needed.
